// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - bus-strobed write FIFO with ready/valid drain and tri-state status word
module io_out_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   busIN,
    input  logic          IO_EN,
    input  logic          IO_OUT,
    output logic [15:0]   busOUT,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    // Pointer width is one bit narrower than the count, which must also represent DEPTH itself.
    localparam int AW = CW - 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          en_d;
    logic          overflow_q;

    logic          push_req;
    logic          pop;
    logic          push_ok;

    // Flags come only from the registered count, so they cannot glitch at clock edges.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_valid = ~empty;

    // Gating with empty forces out_data to zero the instant reset clears the count.
    assign out_data  = empty ? 16'h0000 : mem[rd_ptr];

    // One push per strobe: only the rising edge of IO_EN requests a write.
    assign push_req  = IO_EN & ~en_d;
    assign pop       = out_valid & out_ready;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok   = push_req & (~full | pop);

    // Status word is only driven onto the shared bus while it is being read.
    assign busOUT    = IO_OUT ? {overflow_q, full, empty, {(13 - CW){1'b0}}, count_q} : 16'bz;

    // Strobe edge-detect register; cleared by reset so a held-high strobe counts after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_d <= 1'b0;
        end else begin
            en_d <= IO_EN;
        end
    end

    // Storage array has no reset; only entries behind a valid count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= busIN;
        end
    end

    // Write pointer advances per accepted push and wraps naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // Read pointer advances per pop and wraps the same way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: push and pop in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky drop flag; reading the status word does not clear it, only reset does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (push_req & ~push_ok) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// tb/tb_io_out_fifo.sv - randomized queue-model bench for io_out_fifo
module tb_io_out_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          reset;
    logic [15:0]   busIN;
    logic          IO_EN;
    logic          IO_OUT;
    wire  [15:0]   busOUT;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    int n_cmp;
    int n_bad;

    // Reference model: the FIFO is just a queue plus a sticky flag and the previous strobe level.
    logic [15:0] q[$];
    logic        m_prev_en;
    logic        m_ovf;
    int          max_seen;

    io_out_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .busIN     (busIN),
        .IO_EN     (IO_EN),
        .IO_OUT    (IO_OUT),
        .busOUT    (busOUT),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev_en = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // Compare every visible output against the model's current contents.
    task automatic check_outputs();
        int          sz;
        logic [15:0] st;
        sz = q.size();
        check("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
        if (sz > 0) check("out_data", {16'd0, out_data}, {16'd0, q[0]});
        check("count", 32'(count), 32'(sz));
        check("full", {31'd0, full}, {31'd0, sz == DEPTH});
        check("empty", {31'd0, empty}, {31'd0, sz == 0});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (IO_OUT) begin
            st = 16'(sz);
            st[15] = m_ovf;
            st[14] = (sz == DEPTH);
            st[13] = (sz == 0);
            check("busOUT", {16'd0, busOUT}, {16'd0, st});
        end
        if (sz > max_seen) max_seen = sz;
    endtask

    // One clock: drive at the falling edge, check, then let the model follow the rising edge.
    task automatic cycle(input logic en, input logic [15:0] d, input logic rdy, input logic io);
        logic push_req;
        logic pop;
        IO_EN     = en;
        busIN     = d;
        out_ready = rdy;
        IO_OUT    = io;
        #1;
        check_outputs();
        @(posedge clk);
        push_req = en && !m_prev_en;
        pop      = rdy && (q.size() > 0);
        m_prev_en = en;
        if (push_req && !(q.size() < DEPTH || pop)) m_ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (push_req && (q.size() < DEPTH)) q.push_back(d);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] d);
        cycle(1'b1, d, 1'b0, 1'b1);
        cycle(1'b0, d, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        max_seen = 0;
        reset     = 1'b0;
        IO_EN     = 1'b0;
        busIN     = 16'h0000;
        IO_OUT    = 1'b1;
        out_ready = 1'b0;
        model_reset();

        // Reset state with the status word being read.
        #3;
        check("rst_busOUT", {16'd0, busOUT}, 32'h2000);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single strobe, then a strobe held for five cycles: each pushes once.
        cycle(1'b1, 16'hA5A5, 1'b0, 1'b1);
        check("a5_valid", {31'd0, out_valid}, 32'd1);
        check("a5_data", {16'd0, out_data}, 32'hA5A5);
        check("a5_count", 32'(count), 32'd1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h1111 + 16'(i), 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        check("held_count", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        check("drain_empty", {31'd0, empty}, 32'd1);

        // Fill to four, a fifth push overflows, drain in order.
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_order", {16'd0, out_data}, 32'(i));
            cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        end
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full with simultaneous push and pop: head leaves, new word enters.
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        cycle(1'b1, 16'h0009, 1'b1, 1'b1);
        check("fp_count", 32'(count), 32'd4);
        check("fp_head", {16'd0, out_data}, 32'h0002);
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Ten push/pop pairs force several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1);
            cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        end

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
        end
        check("max_count", 32'(max_seen), 32'(DEPTH));

        // Asynchronous reset mid-transfer with three words held.
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push_word(16'h0A00 + 16'(i));
        check("pre_rst_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        IO_EN     = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_data", {16'd0, out_data}, 32'd0);
        check("async_busOUT", {16'd0, busOUT}, 32'h2000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // IO_EN already high at release counts as a rising edge.
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
        check("rel_edge_count", 32'(count), 32'd1);
        check("rel_edge_data", {16'd0, out_data}, 32'hBEEF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
